// File: rtl/fsm_seq_pkg.sv
// Shared state encoding and parameter defaults for the program-driven sequencer.
// Optional signature output is enabled with macro FSM_SEQ_SIG_EN.
package fsm_seq_pkg;
  localparam int DEPTH_DEF = 16;
  localparam int W_DEF     = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_SM,
    S_PLAY,
    S_DRAIN,
    S_DONE
  } state_t;
endpackage

// File: rtl/fsm_seq_mem.sv
// Program memory: one synchronous write port, one asynchronous read port.
// Contents are intentionally left unreset.
module fsm_seq_mem
  import fsm_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = W_DEF
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fsm_sequencer.sv
// Plays a stored U-word program into an external state machine and captures C.
// Define FSM_SEQ_SIG_EN to add the rotate-XOR signature output sig.
module fsm_sequencer
  import fsm_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [W-1:0]             wr_data,
  input  logic [$clog2(DEPTH):0]   len,
  input  logic                     start,
  input  logic                     abort,
  output logic                     sm_rst,
  output logic [W-1:0]             sm_U,
  input  logic [W-1:0]             sm_C,
  output logic                     busy,
  output logic                     done,
  output logic [W-1:0]             last_C
`ifdef FSM_SEQ_SIG_EN
  ,
  output logic [W-1:0]             sig
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_ONE   = (AW+1)'(1);

  state_t        r_state, w_next;
  logic [AW-1:0] r_idx, w_idx_nx;
  logic [AW:0]   r_len, w_len_nx;
  logic [AW:0]   w_len_clamp;
  logic [AW:0]   w_idx_p1;
  logic          w_last;
  logic          w_we;
  logic [W-1:0]  w_rdata;

  logic          r_sm_rst;
  logic [W-1:0]  r_sm_U;
  logic          r_busy;
  logic          r_done;
  logic [W-1:0]  r_last_C;

  assign w_we        = wr_en && (r_state == S_IDLE);
  assign w_len_clamp = (len > L_DEPTH) ? L_DEPTH : len;
  assign w_idx_p1    = {1'b0, r_idx} + L_ONE;
  assign w_last      = (w_idx_p1 == r_len);

  // Read address is the index of the word about to be presented.
  fsm_seq_mem #(
    .DEPTH(DEPTH),
    .W    (W)
  ) u_mem (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(wr_addr),
    .i_wdata(wr_data),
    .i_raddr(w_idx_nx),
    .o_rdata(w_rdata)
  );

  always_comb begin
    w_next   = r_state;
    w_idx_nx = r_idx;
    w_len_nx = r_len;
    unique case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_next   = S_RST_SM;
          w_len_nx = w_len_clamp;
          w_idx_nx = '0;
        end
      end
      S_RST_SM: begin
        w_idx_nx = '0;
        w_next   = (r_len == '0) ? S_DRAIN : S_PLAY;
      end
      S_PLAY: begin
        if (w_last) w_next = S_DRAIN;
        else        w_idx_nx = w_idx_p1[AW-1:0];
      end
      S_DRAIN: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_len    <= '0;
      r_sm_rst <= 1'b0;
      r_sm_U   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_last_C <= '0;
    end else begin
      r_state  <= w_next;
      r_idx    <= w_idx_nx;
      r_len    <= w_len_nx;
      r_sm_rst <= (w_next == S_RST_SM);
      r_sm_U   <= (w_next == S_PLAY) ? w_rdata : '0;
      r_busy   <= (w_next != S_IDLE);
      r_done   <= (w_next == S_DONE);
      if (r_state == S_DRAIN && w_next == S_DONE)
        r_last_C <= sm_C;
    end
  end

  assign sm_rst = r_sm_rst;
  assign sm_U   = r_sm_U;
  assign busy   = r_busy;
  assign done   = r_done;
  assign last_C = r_last_C;

`ifdef FSM_SEQ_SIG_EN
  logic [W-1:0] r_sig;
  logic         w_samp;

  // Sample C once per played word after the first, plus once in DRAIN.
  assign w_samp = (w_next != S_IDLE) &&
                  ((r_state == S_PLAY && r_idx != '0) ||
                   (r_state == S_DRAIN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig <= '0;
    end else if (r_state == S_IDLE && w_next == S_RST_SM) begin
      r_sig <= '0;
    end else if (w_samp) begin
      r_sig <= {r_sig[W-2:0], r_sig[W-1]} ^ sm_C;
    end
  end

  assign sig = r_sig;
`endif

endmodule
